// File: rtl/polyunit_pkg.sv
// Shared constants and types for the poly unit loader slice.
// - KYBER_Q            : coefficient modulus
// - DATWID_DEF/ADDWID_DEF : default coefficient and RAM address widths
// - mode_t             : run modes handed to the poly unit core
// - state_t            : loader FSM encoding (exposed on the debug port)
package polyunit_pkg;

  localparam int KYBER_Q    = 3329;
  localparam int DATWID_DEF = 12;
  localparam int ADDWID_DEF = 7;

  typedef enum logic [1:0] {
    P_IDLE   = 2'd0,  // load only, no core run
    P_NTT    = 2'd1,
    P_INTT   = 2'd2,
    P_BYPASS = 2'd3
  } mode_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_PAD   = 3'd2,
    S_START = 3'd3,
    S_WAIT  = 3'd4,
    S_FIN   = 3'd5
  } state_t;

endpackage

// File: rtl/polyunit_loader_if.sv
// Bundle of the loader's stream input, core RAM/control port and status.
// Handshake: a beat transfers on a rising clk edge where s_valid and s_ready
// are both 1; s_data/s_last/mode_sel must be stable while s_valid is high,
// and s_ready never depends combinationally on s_valid.
// Modports:
// - slave  : the loader (consumes the stream and core_done, drives the rest)
// - master : the environment (stream source and poly unit core)
interface polyunit_loader_if #(
  parameter int DATWID = 12,
  parameter int ADDWID = 7
) ();
  logic              s_valid;
  logic              s_ready;
  logic [DATWID-1:0] s_data;
  logic              s_last;
  logic [1:0]        mode_sel;
  logic [DATWID-1:0] data_in;
  logic [ADDWID-1:0] add_in;
  logic              wr_en;
  logic [1:0]        mode;
  logic              run;
  logic              core_done;
  logic              busy;
  logic              frame_done;
  logic              err_len;

  modport slave (
    input  s_valid, s_data, s_last, mode_sel, core_done,
    output s_ready, data_in, add_in, wr_en, mode, run, busy, frame_done, err_len
  );

  modport master (
    output s_valid, s_data, s_last, mode_sel, core_done,
    input  s_ready, data_in, add_in, wr_en, mode, run, busy, frame_done, err_len
  );
endinterface

// File: rtl/polyunit_modq_csub.sv
// Combinational reduction of a raw coefficient into [0, KYBER_Q).
// Ports: din (raw coefficient), dout (reduced coefficient).
// One conditional subtract is enough because 2**12-1 - q = 766 < q.
module polyunit_modq_csub
  import polyunit_pkg::*;
#(
  parameter int DATWID = DATWID_DEF
) (
  input  logic [DATWID-1:0] din,
  output logic [DATWID-1:0] dout
);
  localparam logic [DATWID-1:0] Q = DATWID'(KYBER_Q);

  assign dout = (din >= Q) ? din - Q : din;
endmodule

// File: rtl/polyunit_loader.sv
// Upstream feeder for the poly unit core. Accepts one frame of 2**ADDWID
// coefficients, reduces each mod q and writes it into the core's NTT RAM,
// zero-pads short frames, then starts the core with the mode latched on the
// first beat and waits for core_done.
// Ports:
// - clk       : clock, rising edge
// - rst       : synchronous reset, active low
// - bus       : stream in, RAM write port, run/mode/core_done, status flags
// - state_dbg : current FSM state
module polyunit_loader
  import polyunit_pkg::*;
#(
  parameter int DATWID = DATWID_DEF,
  parameter int ADDWID = ADDWID_DEF
) (
  input  logic             clk,
  input  logic             rst,
  polyunit_loader_if.slave bus,
  output state_t           state_dbg
);
  localparam logic [ADDWID-1:0] LAST_ADDR = {ADDWID{1'b1}};

  state_t            state_q, state_n;
  logic [ADDWID-1:0] cnt_q, cnt_n;
  logic [DATWID-1:0] data_q, data_n;
  logic [ADDWID-1:0] addr_q, addr_n;
  logic              wr_q, wr_n;
  logic [1:0]        mode_q, mode_n;
  logic              run_q, run_n;
  logic              busy_q, busy_n;
  logic              fd_q, fd_n;
  logic              err_q, err_n;
  logic [DATWID-1:0] reduced;
  logic              accept;

  polyunit_modq_csub #(.DATWID(DATWID)) u_csub (
    .din  (bus.s_data),
    .dout (reduced)
  );

  // Gated by rst so nothing is offered to the source while reset is held.
  assign bus.s_ready = rst & ((state_q == S_IDLE) | (state_q == S_LOAD));
  assign accept      = bus.s_valid & bus.s_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      mode_q  <= 2'd0;
      run_q   <= 1'b0;
      busy_q  <= 1'b0;
      fd_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      data_q  <= data_n;
      addr_q  <= addr_n;
      wr_q    <= wr_n;
      mode_q  <= mode_n;
      run_q   <= run_n;
      busy_q  <= busy_n;
      fd_q    <= fd_n;
      err_q   <= err_n;
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    data_n  = data_q;
    addr_n  = addr_q;
    wr_n    = 1'b0;
    mode_n  = mode_q;
    run_n   = 1'b0;
    busy_n  = busy_q;
    fd_n    = 1'b0;
    err_n   = err_q;
    case (state_q)
      S_IDLE, S_LOAD: begin
        if (accept) begin
          data_n = reduced;
          addr_n = cnt_q;
          wr_n   = 1'b1;
          cnt_n  = cnt_q + 1'b1;
          if (state_q == S_IDLE) begin
            mode_n = bus.mode_sel;
            busy_n = 1'b1;
          end
          if (cnt_q == LAST_ADDR) begin
            // A full frame always starts the core, even without s_last;
            // the missing marker is only reported.
            if (!bus.s_last) err_n = 1'b1;
            state_n = S_START;
          end else if (bus.s_last) begin
            err_n   = 1'b1;
            state_n = S_PAD;
          end else begin
            state_n = S_LOAD;
          end
        end
      end
      S_PAD: begin
        data_n = '0;
        addr_n = cnt_q;
        wr_n   = 1'b1;
        cnt_n  = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) state_n = S_START;
      end
      S_START: begin
        // No write is issued here, which keeps run one cycle behind the
        // final wr_en.
        cnt_n = '0;
        if (mode_q == P_IDLE) begin
          fd_n    = 1'b1;
          busy_n  = 1'b0;
          state_n = S_IDLE;
        end else begin
          run_n   = 1'b1;
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.core_done) state_n = S_FIN;
      end
      S_FIN: begin
        fd_n    = 1'b1;
        busy_n  = 1'b0;
        cnt_n   = '0;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign bus.data_in    = data_q;
  assign bus.add_in     = addr_q;
  assign bus.wr_en      = wr_q;
  assign bus.mode       = mode_q;
  assign bus.run        = run_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = fd_q;
  assign bus.err_len    = err_q;
  assign state_dbg      = state_q;
endmodule
